mux_input_conditioner: RTL

Front-end conditioning stage for the dice/traffic-light multiplexer. It takes the two raw board inputs, the roll push-button and the mode push-button, and does three things: synchronises both, debounces both, and turns the mode button into a toggled `sel` level. Its `button` and `sel` outputs drive the multiplexer's `button` and `sel` inputs directly, and it shares the multiplexer's `clk` and `rst`.

---
 rtl/mux_input_pkg.sv | 18 +
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/mux_input_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/mux_input_pkg.sv
// Shared definitions for the multiplexer input conditioner: debounce FSM
// state encoding and default timing parameters.
package mux_input_pkg;

   localparam int DefaultDebounceCycles = 16;
   localparam int DefaultSyncStages     = 2;

   localparam logic [1:0] StLow  = 2'd0;
   localparam logic [1:0] StRise = 2'd1;
   localparam logic [1:0] StHigh = 2'd2;
   localparam logic [1:0] StFall = 2'd3;

   // HIGH and FALL share the upper bit, so the debounced level is one state bit.
   function automatic logic stateLevel(input logic [1:0] state);
      return state[1];
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: multi-flop synchroniser followed by a four-state
// debounce FSM that only changes level after an unbroken stable run.
module debounce_channel
   import mux_input_pkg::*;
#(
   parameter int SYNC_STAGES     = DefaultSyncStages,
   parameter int DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int               CntW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [1:0]             state_q, state_d;
   logic [CntW-1:0]        count_q, count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Any sample disagreeing with the pending direction drops the count to zero.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         StLow: begin
            if (s) begin
               state_d = StRise;
               count_d = CntOne;
            end
         end
         StRise: begin
            if (!s) begin
               state_d = StLow;
               count_d = '0;
            end else if (count_q == CntMax) begin
               state_d = StHigh;
               count_d = '0;
            end else begin
               count_d = count_q + CntOne;
            end
         end
         StHigh: begin
            if (!s) begin
               state_d = StFall;
               count_d = CntOne;
            end
         end
         StFall: begin
            if (s) begin
               state_d = StHigh;
               count_d = '0;
            end else if (count_q == CntMax) begin
               state_d = StLow;
               count_d = '0;
            end else begin
               count_d = count_q + CntOne;
            end
         end
         default: begin
            state_d = StLow;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StLow;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign level = stateLevel(state_q);
   // Asserted during the cycle whose closing edge enters HIGH from RISE.
   assign rise  = (state_q == StRise) && s && (count_q == CntMax);

endmodule

// File: rtl/mux_input_conditioner.sv
// Front end for the dice/traffic-light multiplexer: conditions the roll and
// mode buttons and turns debounced mode presses into a toggled select level.
module mux_input_conditioner
   import mux_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DefaultDebounceCycles,
   parameter int SYNC_STAGES     = DefaultSyncStages
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic mode_raw,
   output logic button,
   output logic sel,
   output logic mode_pulse
);

   logic modeRise;
   logic unusedRollRise;
   logic unusedModeLevel;
   logic sel_q, sel_d;
   logic modePulse_q, modePulse_d;

   debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_roll (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw),
      .level(button),
      .rise (unusedRollRise)
   );

   debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode (
      .clk  (clk),
      .rst  (rst),
      .raw  (mode_raw),
      .level(unusedModeLevel),
      .rise (modeRise)
   );

   // Only the debounced rising edge of mode matters; releasing the button is ignored.
   always_comb begin
      sel_d       = sel_q ^ modeRise;
      modePulse_d = modeRise;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q       <= 1'b0;
         modePulse_q <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         modePulse_q <= modePulse_d;
      end
   end

   assign sel        = sel_q;
   assign mode_pulse = modePulse_q;

endmodule
